image_mem_ctrl: RTL and testbench

IMAGE_MEM_CTRL -- requirements
Module: image_mem_ctrl

---
 rtl/img_pkg.sv | 24 ++
 rtl/img_frame_ram.sv | 33 +++
 rtl/image_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_image_mem_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the image frame controller: default geometry, pixel type,
// FSM state encoding and a counter-width helper.
package img_pkg;

  localparam int PIX_W_DEF  = 12;
  localparam int ADDR_W_DEF = 17;
  localparam int NPIX_DEF   = 25;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DUMP  = 3'd4,
    S_DONE  = 3'd5
  } img_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img_frame_ram.sv
// Single frame buffer: one synchronous write port, one asynchronous read port.
// Writes beyond DEPTH are dropped; reads wrap modulo DEPTH.
module img_frame_ram
  import img_pkg::*;
#(
  parameter int DATA_W = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = NPIX_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  ridx;

  // Full-width compare so aliased high addresses never land in the array.
  always_ff @(posedge clk) begin
    if (we && (waddr < ADDR_W'(DEPTH))) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign ridx  = IDX_W'(raddr % ADDR_W'(DEPTH));
  assign rdata = mem[ridx];

endmodule

// File: rtl/image_mem_ctrl.sv
// Frame controller: streams a source frame in, lets conv2d run on it, streams the result out.
// Optional IMG_ADDR_CHECK_EN adds out-of-range address checking and the addr_err port.
//
// state   | meaning
// IDLE    | waiting for go
// LOAD    | accepting NPIX pixels from s_* into src
// START   | one-cycle conv_start pulse
// RUN     | conv2d owns rd/wr ports; wait for conv_ready rise
// DUMP    | streaming dst out on m_*
// DONE    | one-cycle done pulse
module image_mem_ctrl
  import img_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NPIX   = NPIX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              conv_start,
  input  logic              conv_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data
`ifdef IMG_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam int CNT_W = cnt_width(NPIX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPIX - 1);

  img_state_t       state, state_nxt;
  logic [CNT_W-1:0] load_cnt, dump_cnt;
  logic             ready_q;
  logic             load_beat, load_last, dump_beat, dump_last, ready_rise;
  logic             src_we, dst_we;
  logic [PIX_W-1:0] src_rd, dst_rd;

  assign load_last  = (load_cnt == CNT_LAST);
  assign dump_last  = (dump_cnt == CNT_LAST);
  assign load_beat  = (state == S_LOAD) && s_valid;
  assign dump_beat  = (state == S_DUMP) && m_ready;
  assign ready_rise = conv_ready && !ready_q;
  assign src_we     = load_beat;
  assign dst_we     = (state == S_RUN) && wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      dump_cnt <= '0;
      ready_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= conv_ready;
      if (load_beat) begin
        load_cnt <= load_last ? '0 : load_cnt + CNT_W'(1);
      end
      if (dump_beat) begin
        dump_cnt <= dump_last ? '0 : dump_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    conv_start = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:  if (go) state_nxt = S_LOAD;
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid && load_last) state_nxt = S_START;
      end
      S_START: begin
        conv_start = 1'b1;
        state_nxt  = S_RUN;
      end
      // A conv_ready already high on entry leaves ready_q set, so only a fresh rise counts.
      S_RUN:   if (ready_rise) state_nxt = S_DUMP;
      S_DUMP: begin
        m_valid = 1'b1;
        m_last  = dump_last;
        if (m_ready && dump_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign m_data = m_valid ? dst_rd : '0;

  img_frame_ram #(
    .DATA_W (PIX_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (NPIX)
  ) u_src (
    .clk   (clk),
    .we    (src_we),
    .waddr (ADDR_W'(load_cnt)),
    .wdata (s_data),
    .raddr (rd_addr),
    .rdata (src_rd)
  );

  img_frame_ram #(
    .DATA_W (PIX_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (NPIX)
  ) u_dst (
    .clk   (clk),
    .we    (dst_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (ADDR_W'(dump_cnt)),
    .rdata (dst_rd)
  );

`ifdef IMG_ADDR_CHECK_EN
  logic rd_oob, wr_oob;

  assign rd_oob  = (rd_addr >= ADDR_W'(NPIX));
  assign wr_oob  = (wr_addr >= ADDR_W'(NPIX));
  assign rd_data = ((state == S_RUN) && !rd_oob) ? src_rd : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err <= 1'b0;
    end else if ((state == S_IDLE) && go) begin
      addr_err <= 1'b0;
    end else if ((state == S_RUN) && (rd_oob || (wr_en && wr_oob))) begin
      addr_err <= 1'b1;
    end
  end
`else
  assign rd_data = (state == S_RUN) ? src_rd : '0;
`endif

endmodule

// File: tb/tb_image_mem_ctrl.sv
// Directed bench for image_mem_ctrl: read/write tables plus hand-written multi-cycle frames.
module tb_image_mem_ctrl;
  import img_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        busy, done;
  logic        s_valid = 1'b0;
  logic [11:0] s_data = '0;
  logic        s_ready;
  logic        m_valid, m_last;
  logic [11:0] m_data;
  logic        m_ready = 1'b0;
  logic        conv_start;
  logic        conv_ready = 1'b0;
  logic [16:0] rd_addr = '0;
  logic [11:0] rd_data;
  logic        wr_en = 1'b0;
  logic [16:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
`ifdef IMG_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;
  int cs_count = 0;

  image_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .busy       (busy),
    .done       (done),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .conv_start (conv_start),
    .conv_ready (conv_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
`ifdef IMG_ADDR_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (conv_start) cs_count++;

  typedef struct {
    logic [16:0] addr;
    logic [11:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tbl[7];
  rd_vec_t rd_tbl3[4];
  pix_t    dst_exp[25];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_frame(input logic [11:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 12'(i);
      step();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rd_tbl[0] = '{17'd0,  12'h001};
    rd_tbl[1] = '{17'd4,  12'h005};
    rd_tbl[2] = '{17'd24, 12'h019};
    rd_tbl[3] = '{17'd12, 12'h00D};
`ifdef IMG_ADDR_CHECK_EN
    rd_tbl[4] = '{17'd25,      12'h000};
    rd_tbl[5] = '{17'd30,      12'h000};
    rd_tbl[6] = '{17'h10004,   12'h000};
`else
    rd_tbl[4] = '{17'd25,      12'h001};
    rd_tbl[5] = '{17'd30,      12'h006};
    rd_tbl[6] = '{17'h10004,   12'h010};
`endif
    rd_tbl3[0] = '{17'd0,  12'h100};
    rd_tbl3[1] = '{17'd9,  12'h109};
    rd_tbl3[2] = '{17'd10, 12'h10A};
    rd_tbl3[3] = '{17'd24, 12'h118};
    for (int i = 0; i < 25; i++) dst_exp[i] = (i == 3) ? 12'hABC : 12'h200 + 12'(i);

    // ---------------- frame 1: basic load / run / dump
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_conv_start", 32'(conv_start), 32'd0);
    rst = 1'b1;
    step();
    check("idle_s_ready", 32'(s_ready), 32'd0);
    go = 1'b1;
    step();
    go = 1'b0;
    check("load_s_ready", 32'(s_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 25; i++) begin
      s_valid = 1'b1;
      s_data  = 12'(i + 1);
      #1;
      check("load_no_start", 32'(conv_start), 32'd0);
      step();
    end
    s_valid = 1'b0;
    check("start_pulse", 32'(conv_start), 32'd1);
    check("start_s_ready", 32'(s_ready), 32'd0);
    step();
    check("run_start_low", 32'(conv_start), 32'd0);
    check("run_busy", 32'(busy), 32'd1);
    check("start_count", 32'(cs_count), 32'd1);

    for (int i = 0; i < 7; i++) begin
      rd_addr = rd_tbl[i].addr;
      #1;
      check($sformatf("rd_tbl[%0d]", i), 32'(rd_data), 32'(rd_tbl[i].exp));
    end
    step();
`ifdef IMG_ADDR_CHECK_EN
    check("addr_err_set", 32'(addr_err), 32'd1);
`endif
    rd_addr = '0;

    for (int i = 0; i < 25; i++) begin
      wr_en   = 1'b1;
      wr_addr = 17'(i);
      wr_data = dst_exp[i];
      step();
    end
    wr_addr = 17'd25;
    wr_data = 12'hFFF;
    step();
    wr_addr = 17'h10002;
    wr_data = 12'hEEE;
    step();
    wr_en = 1'b0;
    check("run_no_dump", 32'(m_valid), 32'd0);

    conv_ready = 1'b1;
    m_ready    = 1'b1;
    step();
    check("dump_entry", 32'(m_valid), 32'd1);
    for (int b = 0; b < 25; b++) begin
      check($sformatf("f1_data[%0d]", b), 32'(m_data), 32'(dst_exp[b]));
      check($sformatf("f1_last[%0d]", b), 32'(m_last), (b == 24) ? 32'd1 : 32'd0);
      step();
    end
    check("f1_done", 32'(done), 32'd1);
    check("f1_done_m_valid", 32'(m_valid), 32'd0);
    step();
    check("f1_done_clear", 32'(done), 32'd0);
    check("f1_idle_busy", 32'(busy), 32'd0);
`ifdef IMG_ADDR_CHECK_EN
    check("addr_err_sticky", 32'(addr_err), 32'd1);
`endif

    // ---------------- frame 2: stale conv_ready, gapped load, stalled dump
    m_ready = 1'b0;
    go = 1'b1;
    step();
    go = 1'b0;
`ifdef IMG_ADDR_CHECK_EN
    check("addr_err_go_clear", 32'(addr_err), 32'd0);
`endif
    wr_en   = 1'b1;
    wr_addr = 17'd7;
    wr_data = 12'h777;
    for (int i = 0; i < 25; i++) begin
      s_valid = 1'b0;
      s_data  = 12'hFFF;
      step();
      s_valid = 1'b1;
      s_data  = 12'h040 + 12'(i);
      step();
    end
    s_valid = 1'b0;
    wr_en   = 1'b0;
    check("f2_start", 32'(conv_start), 32'd1);
    step();
    s_valid = 1'b1;
    s_data  = 12'h555;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("f2_stale_ready", 32'(m_valid), 32'd0);
      check("f2_run_s_ready", 32'(s_ready), 32'd0);
      step();
    end
    s_valid = 1'b0;
    conv_ready = 1'b0;
    step();
    conv_ready = 1'b1;
    #1;
    check("f2_before_rise", 32'(m_valid), 32'd0);
    step();
    check("f2_dump_entry", 32'(m_valid), 32'd1);
    begin
      int beat;
      int seen_done;
      beat = 0;
      seen_done = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        m_ready = (cyc % 2 == 0);
        #1;
        if (done) begin
          seen_done = 1;
          break;
        end
        if (m_valid && beat < 25) begin
          check($sformatf("f2_data[%0d]", beat), 32'(m_data), 32'(dst_exp[beat]));
          check($sformatf("f2_last[%0d]", beat), 32'(m_last), (beat == 24) ? 32'd1 : 32'd0);
          if (m_ready) beat++;
        end
        step();
      end
      check("f2_beats", 32'(beat), 32'd25);
      check("f2_done_seen", 32'(seen_done), 32'd1);
    end
    m_ready = 1'b0;
    step();
    check("f2_idle", 32'(busy), 32'd0);
    conv_ready = 1'b0;

    // ---------------- frame 3: reset mid-load, then restart
    go = 1'b1;
    step();
    go = 1'b0;
    load_frame(12'h300, 10);
    s_valid = 1'b1;
    s_data  = 12'h30A;
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_s_ready", 32'(s_ready), 32'd0);
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_m_last", 32'(m_last), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_conv_start", 32'(conv_start), 32'd0);
    check("arst_m_data", 32'(m_data), 32'd0);
    check("arst_rd_data", 32'(rd_data), 32'd0);
    s_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("post_rst_idle", 32'(busy), 32'd0);
    go = 1'b1;
    step();
    go = 1'b0;
    load_frame(12'h100, 25);
    check("f3_start", 32'(conv_start), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      rd_addr = rd_tbl3[i].addr;
      #1;
      check($sformatf("rd_tbl3[%0d]", i), 32'(rd_data), 32'(rd_tbl3[i].exp));
    end
    rd_addr    = '0;
    conv_ready = 1'b1;
    m_ready    = 1'b1;
    step();
    begin
      int lasts;
      int seen_done;
      lasts = 0;
      seen_done = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (done) begin
          seen_done = 1;
          break;
        end
        if (m_last) lasts++;
        step();
      end
      check("f3_done_seen", 32'(seen_done), 32'd1);
      check("f3_last_count", 32'(lasts), 32'd1);
    end
    check("f3_start_total", 32'(cs_count), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
